mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the instruction-fetch requester (F stage) and the
//  data load/store requester (E/M stage) in the multi-cycle PD core.
//  Grants one request at a time and drives the memory port. Returns each read response to its
//  owner after a fixed latency. Prioritises data over fetch, with an anti-starvation limit.
// PARAMETERS
//  AWIDTH        32  address width
//  DWIDTH        32  data width
//  MEM_LATENCY   1   cycles from grant to mem_rdata valid (legal range >=1)
//  STARVE_LIMIT  4   consecutive data grants after which a waiting fetch is served first
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  f_req_valid   in   1       fetch request present
//  f_req_addr    in   AWIDTH  fetch address (PC)
//  f_req_ready   out  1       fetch request accepted this cycle
//  f_resp_valid  out  1       fetch read data valid (1-cycle pulse)
//  f_resp_data   out  DWIDTH  fetched instruction
//  d_req_valid   in   1       data request present
//  d_req_addr    in   AWIDTH  data address (ALU result)
//  d_req_we      in   1       1=store, 0=load
//  d_req_size    in   2       access size (funct3[1:0]: 0=B, 1=H, 2=W)
//  d_req_wdata   in   DWIDTH  store data
//  d_req_ready   out  1       data request accepted this cycle
//  d_resp_valid  out  1       load data / store ack valid (1-cycle pulse)
//  d_resp_data   out  DWIDTH  load data; 0 for store ack
//  mem_en        out  1       memory access strobe
//  mem_addr      out  AWIDTH  memory address
//  mem_we        out  1       memory write enable
//  mem_size      out  2       memory access size
//  mem_wdata     out  DWIDTH  memory write data
//  mem_rdata     in   DWIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, owner=none, lat_cnt=0, starve_cnt=0. All outputs 0.
//    An in-flight transaction is dropped with no response pulse.
//  - States: IDLE, BUSY. Requests are accepted only in IDLE.
//  - IDLE, arbitration (combinational):
//      * only one valid -> that requester wins;
//      * both valid -> data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
//  - Winner's *_req_ready=1 in the same cycle. mem_en=1, and mem_addr/we/size/wdata are driven
//    combinationally from the winner's request. For a fetch: mem_we=0, mem_size=2.
//  - On the accept edge: latch owner; lat_cnt<=MEM_LATENCY; state<=BUSY.
//  - BUSY: mem_en=0, both readys 0. lat_cnt decrements each cycle.
//  - Response: when lat_cnt==1 in BUSY, the owner's *_resp_valid=1 for exactly that cycle.
//      * Read: *_resp_data=mem_rdata. Store: d_resp_data=0.
//      * Next state is IDLE.
//  - Timing: accept at cycle T -> resp at T+MEM_LATENCY -> next accept earliest T+MEM_LATENCY+1.
//  - starve_cnt, updated on the accept edge:
//      * +1 (saturating at STARVE_LIMIT) when data is granted while f_req_valid=1;
//      * cleared when fetch is granted or f_req_valid=0.
//  - Idle outputs: when not granting, mem_* outputs are 0. resp_data outputs are 0 when the
//    matching resp_valid is 0.
//  - Requester rules: a requester holds valid/addr/data stable until ready. Dropping valid
//    before ready is legal and cancels the request with no side effect.
//  - No address-alignment checking; misaligned accesses are forwarded unchanged.
// TESTING
//  1 Fetch only, LAT=1: f_req addr=0x01000000, mem_rdata=0xfd010113 at T+1 -> f_req_ready@T,
//    mem_en@T, f_resp_valid@T+1 data=0xfd010113, next fetch accepted @T+2.
//  2 Simultaneous: fetch 0x01000014 + load 0x010001e8 @T -> d_req_ready@T, d_resp@T+1,
//    f_req_ready@T+2, f_resp@T+3.
//  3 Starvation, LIMIT=4: both valid continuously -> grants D,D,D,D,F,D...
//    starve_cnt 0,1,2,3,4,0.
//  4 Store: d_req we=1 addr=0x0100002c size=2 wdata=0x0000002c -> mem_we=1 mem_size=2 for one
//    cycle; d_resp_valid pulse @T+1 with data=0; no f_resp.
//  5 LAT=3 load: accept @T -> d_resp_valid only @T+3; readys 0 @T+1..T+3; new accept @T+4.
//  6 Reset mid-BUSY, LAT=3: reset low @T+1 -> outputs 0 immediately, no resp pulse.
//    After release, an IDLE fetch is accepted on the first cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data load/store.
// Data has priority; a fetch that has waited through STARVE_LIMIT data grants goes first.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req_valid,
    input  logic [AWIDTH-1:0] f_req_addr,
    output logic              f_req_ready,
    output logic              f_resp_valid,
    output logic [DWIDTH-1:0] f_resp_data,

    input  logic              d_req_valid,
    input  logic [AWIDTH-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic [DWIDTH-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DWIDTH-1:0] d_resp_data,

    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_ownerData;
    logic            r_ownerStore;
    logic [LW-1:0]   r_latCnt;
    logic [SW-1:0]   r_starveCnt;

    logic            w_idle;
    logic            w_starved;
    logic            w_grantD;
    logic            w_grantF;
    logic            w_respPulse;

    // Grants are gated by reset so every output is quiet while reset is held.
    always_comb begin
        w_idle      = (r_state == IDLE) && reset;
        w_starved   = (r_starveCnt == STARVE_MAX);
        w_grantD    = w_idle && d_req_valid && !(f_req_valid && w_starved);
        w_grantF    = w_idle && f_req_valid && !w_grantD;
        w_respPulse = (r_state == BUSY) && (r_latCnt == LW'(1)) && reset;
    end

    always_comb begin
        f_req_ready = w_grantF;
        d_req_ready = w_grantD;
        mem_en      = w_grantD || w_grantF;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_size    = 2'd0;
        mem_wdata   = '0;
        if (w_grantD) begin
            mem_addr  = d_req_addr;
            mem_we    = d_req_we;
            mem_size  = d_req_size;
            mem_wdata = d_req_wdata;
        end else if (w_grantF) begin
            mem_addr  = f_req_addr;
            mem_size  = 2'd2;
        end
    end

    always_comb begin
        f_resp_valid = w_respPulse && !r_ownerData;
        d_resp_valid = w_respPulse && r_ownerData;
        f_resp_data  = f_resp_valid ? mem_rdata : '0;
        d_resp_data  = (d_resp_valid && !r_ownerStore) ? mem_rdata : '0;
    end

    // Starvation count only moves on an accept: it counts data grants a waiting fetch sat through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ownerData  <= 1'b0;
            r_ownerStore <= 1'b0;
            r_latCnt     <= '0;
            r_starveCnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantD || w_grantF) begin
                        r_ownerData  <= w_grantD;
                        r_ownerStore <= w_grantD && d_req_we;
                        r_latCnt     <= LAT_INIT;
                        r_state      <= BUSY;
                        if (w_grantF || !f_req_valid) begin
                            r_starveCnt <= '0;
                        end else if (!w_starved) begin
                            r_starveCnt <= r_starveCnt + SW'(1);
                        end
                    end
                end
                BUSY: begin
                    r_latCnt <= r_latCnt - LW'(1);
                    if (r_latCnt == LW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
